// File: rtl/pdm_pkg.sv
// Constants and sizing helpers shared by the PDM playback and capture paths.
package pdm_pkg;

  // Both ends of the link treat a 1 on the PDM wire as positive full scale.
  localparam logic PDM_POS = 1'b1;

  function automatic int fs(input int sample_depth);
    return 1 << (sample_depth - 1);
  endfunction

  function automatic int int_w(input int sample_depth);
    return sample_depth + 4;
  endfunction

  function automatic int sat_lim(input int sample_depth);
    return 1 << (sample_depth + 2);
  endfunction

endpackage

// File: rtl/pdm_sd2_mod.sv
// Second-order sigma-delta modulator: one output bit per bit_stb from a held PCM value.
module pdm_sd2_mod
  import pdm_pkg::*;
#(
  parameter int SAMPLE_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_stb,
  input  logic [SAMPLE_DEPTH-1:0] x,
  output logic                    bit_out
);

  localparam int W  = int_w(SAMPLE_DEPTH);
  localparam int WS = W + 1;
  localparam logic signed [WS-1:0] POS_FS  = WS'(fs(SAMPLE_DEPTH));
  localparam logic signed [WS-1:0] NEG_FS  = -POS_FS;
  localparam logic signed [WS-1:0] POS_LIM = WS'(sat_lim(SAMPLE_DEPTH));
  localparam logic signed [WS-1:0] NEG_LIM = -POS_LIM;

  logic signed [W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic signed [W-1:0]  i1_n, i2_n;
  logic signed [WS-1:0] x_ext, fb;
  logic                 bit_q, bit_d;

  // Sums are formed one bit wider than the integrators so clamping sees the true value.
  function automatic logic signed [W-1:0] sat(input logic signed [WS-1:0] v);
    logic signed [WS-1:0] c;
    if (v > POS_LIM) c = POS_LIM;
    else if (v < NEG_LIM) c = NEG_LIM;
    else c = v;
    return W'(c);
  endfunction

  always_comb begin
    x_ext = WS'($signed(x));
    fb    = (bit_q == PDM_POS) ? POS_FS : NEG_FS;
    i1_n  = sat(WS'(i1_q) + x_ext - fb);
    i2_n  = sat(WS'(i2_q) + WS'(i1_n) - fb);
    i1_d  = i1_q;
    i2_d  = i2_q;
    bit_d = bit_q;
    if (bit_stb) begin
      i1_d  = i1_n;
      i2_d  = i2_n;
      bit_d = i2_n[W-1] ? ~PDM_POS : PDM_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/pdm_speaker.sv
// PCM-to-PDM transmitter: bit-clock divider, sample-slot counter, one-deep skid buffer
// and the second-order modulator driving pdm_data.
module pdm_speaker
  import pdm_pkg::*;
#(
  parameter int SAMPLE_DEPTH = 16,
  parameter int CLK_DIV      = 2,
  parameter int OSR          = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_DEPTH-1:0] audio_in,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  output logic                    pdm_clk,
  output logic                    pdm_data,
  output logic                    underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OSR_W = $clog2(OSR);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    pdm_clk_q, pdm_clk_d;
  logic [SAMPLE_DEPTH-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic                    nxt_full_q, nxt_full_d;
  logic                    underrun_q, underrun_d;
  logic                    bit_stb, smp_stb, accept;

  always_comb begin
    bit_stb     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    smp_stb     = bit_stb && (bit_cnt_q == OSR_W'(OSR - 1));
    audio_ready = !nxt_full_q && !rst;
    accept      = audio_valid && audio_ready;

    div_cnt_d = bit_stb ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    if (bit_stb) bit_cnt_d = smp_stb ? '0 : bit_cnt_q + OSR_W'(1);

    // pdm_clk rises with the new data bit, so the receiver samples on the falling edge.
    pdm_clk_d = pdm_clk_q;
    if (bit_stb) pdm_clk_d = 1'b1;
    else if (div_cnt_q == DIV_W'(CLK_DIV / 2 - 1)) pdm_clk_d = 1'b0;

    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    underrun_d = smp_stb && !nxt_full_q;
    if (smp_stb && nxt_full_q) begin
      cur_d      = nxt_q;
      nxt_full_d = 1'b0;
    end
    if (accept) begin
      nxt_d      = audio_in;
      nxt_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pdm_clk_q  <= 1'b0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      underrun_q <= underrun_d;
    end
  end

  pdm_sd2_mod #(
    .SAMPLE_DEPTH(SAMPLE_DEPTH)
  ) u_mod (
    .clk    (clk),
    .rst    (rst),
    .bit_stb(bit_stb),
    .x      (cur_q),
    .bit_out(pdm_data)
  );

  assign pdm_clk  = pdm_clk_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_speaker.sv
// Bench for pdm_speaker: cycle model of the transmitter, sample scoreboard and per-scenario tasks.
module tb_pdm_speaker;

  localparam int SD      = 16;
  localparam int CLK_DIV = 2;
  localparam int OSR     = 64;
  localparam int PERIOD  = OSR * CLK_DIV;
  localparam int FS      = 1 << (SD - 1);
  localparam int LIM     = 1 << (SD + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SD-1:0] audio_in = '0;
  logic          audio_valid = 1'b0;
  logic          audio_ready, pdm_clk, pdm_data, underrun;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  int m_div = 0, m_bit = 0, m_cur = 0, m_i1 = 0, m_i2 = 0;
  bit m_full = 1'b0, m_pdm = 1'b0, m_pclk = 1'b0, m_under = 1'b0;
  int sb_q[$];

  pdm_speaker #(.SAMPLE_DEPTH(SD), .CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .pdm_clk(pdm_clk), .pdm_data(pdm_data), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic model_step();
    bit bstb, sstb, acc;
    int fb;
    if (rst) begin
      m_div = 0; m_bit = 0; m_cur = 0; m_i1 = 0; m_i2 = 0;
      m_full = 0; m_pdm = 0; m_pclk = 0; m_under = 0;
      sb_q.delete();
    end else begin
      bstb = (m_div == CLK_DIV - 1);
      sstb = bstb && (m_bit == OSR - 1);
      acc  = audio_valid && !m_full;
      m_under = sstb && !m_full;
      if (bstb) begin
        m_pclk = 1'b1;
        fb = m_pdm ? FS : -FS;
        m_i1 = clampi(m_i1 + m_cur - fb);
        m_i2 = clampi(m_i2 + m_i1 - fb);
        m_pdm = (m_i2 >= 0);
      end else if (m_div == CLK_DIV / 2 - 1) begin
        m_pclk = 1'b0;
      end
      if (sstb && m_full) begin
        m_cur = sb_q.pop_front();
        m_full = 1'b0;
      end
      if (acc) begin
        sb_q.push_back(int'($signed(audio_in)));
        m_full = 1'b1;
      end
      m_div = bstb ? 0 : m_div + 1;
      if (bstb) m_bit = sstb ? 0 : m_bit + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison of every output and of each cur load against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      n_vec++;
      if (pdm_data !== m_pdm) begin
        n_err++; $display("FAIL mon_pdm_data t=%0t got %b expected %b", $time, pdm_data, m_pdm);
      end
      n_vec++;
      if (pdm_clk !== m_pclk) begin
        n_err++; $display("FAIL mon_pdm_clk t=%0t got %b expected %b", $time, pdm_clk, m_pclk);
      end
      n_vec++;
      if (underrun !== m_under) begin
        n_err++; $display("FAIL mon_underrun t=%0t got %b expected %b", $time, underrun, m_under);
      end
      n_vec++;
      if (audio_ready !== (!m_full && !rst)) begin
        n_err++; $display("FAIL mon_ready t=%0t got %b expected %b", $time, audio_ready, !m_full && !rst);
      end
      n_vec++;
      if (int'($signed(dut.cur_q)) != m_cur) begin
        n_err++; $display("FAIL mon_cur t=%0t got %0d expected %0d", $time, $signed(dut.cur_q), m_cur);
      end
    end
  end

  task automatic run_bits(input int nbits, input bit rnd, output int ones, output int rises,
                          output int highs, output int unders, output int accs, output int rdy_hi,
                          output int bad_gap, output int max_abs);
    bit prev;
    int last, a;
    ones = 0; rises = 0; highs = 0; unders = 0; accs = 0; rdy_hi = 0; bad_gap = 0; max_abs = 0;
    last = -1;
    prev = pdm_clk;
    for (int c = 0; c < nbits * CLK_DIV; c++) begin
      @(posedge clk); #1;
      if (rnd) audio_in = SD'($urandom);
      @(negedge clk);
      if (pdm_clk && !prev) begin
        rises++;
        ones += int'(pdm_data);
      end
      prev = pdm_clk;
      highs += int'(pdm_clk);
      unders += int'(underrun);
      if (audio_ready) begin
        rdy_hi++;
        if (audio_valid) begin
          if (last >= 0 && c - last != PERIOD) bad_gap++;
          last = c;
          accs++;
        end
      end
      a = $signed(dut.u_mod.i1_q); if (a < 0) a = -a; if (a > max_abs) max_abs = a;
      a = $signed(dut.u_mod.i2_q); if (a < 0) a = -a; if (a > max_abs) max_abs = a;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; audio_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; @(negedge clk);
    n_vec++; if (audio_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b expected 0", audio_ready); end
    n_vec++; if (pdm_clk !== 1'b0) begin n_err++; $display("FAIL rst_pdm_clk got %b expected 0", pdm_clk); end
    n_vec++; if (pdm_data !== 1'b0) begin n_err++; $display("FAIL rst_pdm_data got %b expected 0", pdm_data); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got %b expected 0", underrun); end
    mon_en = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++; if (audio_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b expected 1", audio_ready); end
  endtask

  task automatic test_idle();
    int o, r, h, u, a, rh, bg, mx;
    audio_valid = 1'b0;
    run_bits(1024, 1'b0, o, r, h, u, a, rh, bg, mx);
    n_vec++; if (o < 510 || o > 514) begin n_err++; $display("FAIL idle_density got %0d ones expected 512+-2", o); end
    n_vec++; if (r != 1024) begin n_err++; $display("FAIL idle_clk_rises got %0d expected 1024", r); end
    n_vec++; if (h != 1024 * CLK_DIV / 2) begin n_err++; $display("FAIL idle_clk_duty got %0d high expected %0d", h, 1024 * CLK_DIV / 2); end
    n_vec++; if (u != 1024 / OSR) begin n_err++; $display("FAIL idle_underruns got %0d expected %0d", u, 1024 / OSR); end
  endtask

  task automatic test_const(input int value, input int lo, input int hi, input bit fullscale);
    int o, r, h, u, a, rh, bg, mx;
    audio_in = SD'(value); audio_valid = 1'b1;
    run_bits(3 * OSR, 1'b0, o, r, h, u, a, rh, bg, mx);
    run_bits(1024, 1'b0, o, r, h, u, a, rh, bg, mx);
    n_vec++;
    if (o < lo || o > hi) begin
      n_err++; $display("FAIL const_density in=%0d got %0d ones expected %0d..%0d", value, o, lo, hi);
    end
    if (fullscale) begin
      n_vec++;
      if (mx > LIM) begin n_err++; $display("FAIL integrator_bound in=%0d got %0d expected <=%0d", value, mx, LIM); end
    end
  endtask

  task automatic test_back_to_back();
    int o, r, h, u, a, rh, bg, mx;
    audio_valid = 1'b1;
    run_bits(8 * OSR, 1'b1, o, r, h, u, a, rh, bg, mx);
    n_vec++; if (a != 8) begin n_err++; $display("FAIL b2b_accepts got %0d expected 8", a); end
    n_vec++; if (rh != 8) begin n_err++; $display("FAIL b2b_ready_cycles got %0d expected 8", rh); end
    n_vec++; if (bg != 0) begin n_err++; $display("FAIL b2b_accept_gap got %0d bad gaps expected 0", bg); end
  endtask

  task automatic test_underrun();
    int o, r, h, u, a, rh, bg, mx;
    bit got;
    audio_valid = 1'b0;
    run_bits(2 * OSR, 1'b0, o, r, h, u, a, rh, bg, mx);
    audio_in = 16'h1234; audio_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2 * PERIOD && !got; c++) begin
      @(negedge clk);
      if (audio_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; audio_valid = 1'b0;
    n_vec++; if (!got) begin n_err++; $display("FAIL under_accept_timeout got 0 expected 1"); end
    run_bits(OSR, 1'b0, o, r, h, u, a, rh, bg, mx);
    run_bits(4 * OSR, 1'b0, o, r, h, u, a, rh, bg, mx);
    n_vec++; if (u != 4) begin n_err++; $display("FAIL under_pulses got %0d expected 4", u); end
    n_vec++; if (dut.cur_q !== 16'h1234) begin n_err++; $display("FAIL under_cur_hold got %h expected 1234", dut.cur_q); end
  endtask

  task automatic test_reset_mid();
    int o, r, h, u, a, rh, bg, mx;
    bit low;
    audio_in = 16'hFB2E; audio_valid = 1'b1;
    low = 1'b0;
    for (int c = 0; c < 2 * PERIOD && !low; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!audio_ready) low = 1'b1;
    end
    n_vec++; if (!low) begin n_err++; $display("FAIL mid_fill_timeout got 0 expected 1"); end
    @(posedge clk); #1; rst = 1'b1; audio_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (audio_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b expected 0", audio_ready); end
    n_vec++; if (pdm_clk !== 1'b0) begin n_err++; $display("FAIL mid_rst_pdm_clk got %b expected 0", pdm_clk); end
    n_vec++; if (pdm_data !== 1'b0) begin n_err++; $display("FAIL mid_rst_pdm_data got %b expected 0", pdm_data); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_underrun got %b expected 0", underrun); end
    n_vec++; if (dut.cur_q !== '0) begin n_err++; $display("FAIL mid_rst_cur got %h expected 0000", dut.cur_q); end
    @(posedge clk); #1; rst = 1'b0; audio_in = 16'd999; audio_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (audio_ready !== 1'b1) begin n_err++; $display("FAIL mid_post_ready got %b expected 1", audio_ready); end
    @(posedge clk); #1; audio_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (audio_ready !== 1'b0) begin n_err++; $display("FAIL mid_post_ready_drop got %b expected 0", audio_ready); end
    run_bits(OSR + 2, 1'b0, o, r, h, u, a, rh, bg, mx);
    n_vec++; if (dut.cur_q !== 16'd999) begin n_err++; $display("FAIL mid_post_load got %0d expected 999", dut.cur_q); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_const(16384, 758, 778, 1'b0);
    test_const(-16384, 246, 266, 1'b0);
    test_const(32767, 1014, 1024, 1'b1);
    test_const(-32768, 0, 10, 1'b1);
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
